// File: rtl/crc_pkg.sv
//------------------------------------------------------------------------------
// crc_pkg : shared FSM state encoding and bit-reversal helper for the CRC engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [31:0] rev_bits(input logic [31:0] v, input int n);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        r = {r[30:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_beat_step.sv
//------------------------------------------------------------------------------
// crc_beat_step : one message beat of W bits folded into an N-bit CRC, combinational
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crc_beat_step #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic [N-1:0] i_crc,
  input  logic [W-1:0] i_data,
  input  logic [N-1:0] i_taps,
  input  logic         i_refin,
  output logic [N-1:0] o_crc
);

  logic [W-1:0] w_data_rev;
  logic [W-1:0] w_ord;
  logic [N-1:0] w_poly;
  logic [N-1:0] w_c;
  logic         w_fb;

  for (genvar g = 0; g < W; g++) begin : g_rev
    assign w_data_rev[g] = i_data[W-1-g];
  end

  // LSB-first consumption is MSB-first consumption of the reversed beat.
  assign w_poly = i_taps | N'(1);

  always_comb begin
    w_ord = i_refin ? w_data_rev : i_data;
    w_c   = i_crc;
    w_fb  = 1'b0;
    for (int i = 0; i < W; i++) begin
      w_fb  = w_c[N-1] ^ w_ord[W-1];
      w_c   = {w_c[N-2:0], 1'b0} ^ (w_fb ? w_poly : '0);
      w_ord = w_ord << 1;
    end
    o_crc = w_c;
  end

endmodule

`default_nettype wire

// File: rtl/crc_stream_engine.sv
//------------------------------------------------------------------------------
// crc_stream_engine : framed streaming CRC, runtime polynomial/init/xorout/reflection
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] cfg_taps,
  input  logic [N-1:0] cfg_init,
  input  logic [N-1:0] cfg_xorout,
  input  logic         cfg_refin,
  input  logic         cfg_refout,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_crc,
  output logic         busy
);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_crc;
  logic [N-1:0] r_taps;
  logic [N-1:0] r_xorout;
  logic [N-1:0] r_out_crc;
  logic         r_refin;
  logic         r_refout;
  logic [N-1:0] w_crc_next;
  logic [N-1:0] w_crc_fin;
  logic         w_start;
  logic         w_accept;

  crc_beat_step #(
    .N (N),
    .W (W)
  ) u_step (
    .i_crc   (r_crc),
    .i_data  (in_data),
    .i_taps  (r_taps),
    .i_refin (r_refin),
    .o_crc   (w_crc_next)
  );

  assign w_crc_fin = (r_refout ? N'(rev_bits(32'(w_crc_next), N)) : w_crc_next) ^ r_xorout;
  assign out_crc   = r_out_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // abort outranks both a beat accept and an out_ready handshake.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = (r_state != ST_IDLE);
    w_start      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = start & ~abort;
        if (w_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        w_accept = in_valid & ~abort;
        if (abort) w_state_next = ST_IDLE;
        else if (w_accept && in_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc     <= '0;
      r_taps    <= '0;
      r_xorout  <= '0;
      r_refin   <= 1'b0;
      r_refout  <= 1'b0;
      r_out_crc <= '0;
    end else begin
      if (w_start) begin
        r_crc    <= cfg_init;
        r_taps   <= cfg_taps;
        r_xorout <= cfg_xorout;
        r_refin  <= cfg_refin;
        r_refout <= cfg_refout;
      end
      if (w_accept) begin
        r_crc <= w_crc_next;
        if (in_last) r_out_crc <= w_crc_fin;
      end
    end
  end

endmodule

`default_nettype wire
